// File: rtl/mmu_pkg.sv
// MMU shared types: permission bits, walker state encoding and the
// Sv39/Sv48 PTE field positions used by the page walker.
package mmu_pkg;

  localparam int VPN_BITS  = 9;
  localparam int PAGE_BITS = 12;

  localparam int PTE_V   = 0;
  localparam int PTE_R   = 1;
  localparam int PTE_W   = 2;
  localparam int PTE_X   = 3;
  localparam int PPN_LSB = 10;
  localparam int PPN_MSB = 53;

  typedef logic [7:0] tlb_perm_bits;

  typedef enum logic [1:0] {
    PTW_IDLE  = 2'd0,
    PTW_FETCH = 2'd1,
    PTW_DONE  = 2'd2,
    PTW_DRAIN = 2'd3
  } ptw_state_t;

endpackage

// File: rtl/page_walker_if.sv
// Page walker bus: TLB miss ports, walk results, flush, root pointer
// and the D-cache physical read port. master = TLB/D-cache side.
interface page_walker_if
  import mmu_pkg::*;
#(
  parameter int NPORTS = 2
) ();

  logic [NPORTS-1:0]       req_valid;
  logic [NPORTS-1:0][63:0] req_addr;
  logic [NPORTS-1:0]       resp_valid;
  logic [63:0]             resp_addr;
  tlb_perm_bits            resp_perms;
  logic                    resp_fault;
  logic                    flush;
  logic                    use_dcache;
  logic [63:0]             dcache_req_addr;
  logic                    dcache_resp_valid;
  logic [63:0]             dcache_resp_data;
  logic [63:0]             root_pt_addr;

  modport master (
    output req_valid, req_addr, flush,
    output dcache_resp_valid, dcache_resp_data,
    output root_pt_addr,
    input  resp_valid, resp_addr, resp_perms,
    input  resp_fault, use_dcache, dcache_req_addr
  );

  modport slave (
    input  req_valid, req_addr, flush,
    input  dcache_resp_valid, dcache_resp_data,
    input  root_pt_addr,
    output resp_valid, resp_addr, resp_perms,
    output resp_fault, use_dcache, dcache_req_addr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first
// request at or after ptr, wrapping. Ports: req, ptr in; grant out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] mask;
  logic [N-1:0] upper;
  logic [N-1:0] pick;

  // Requests at or above ptr win; otherwise wrap to the lowest.
  assign mask  = ~((N'(1) << ptr) - N'(1));
  assign upper = req & mask;
  assign pick  = (|upper) ? upper : req;
  assign grant = pick & (~pick + N'(1));

endmodule

// File: rtl/page_walker.sv
// Sv39/Sv48 page-table walker for NPORTS TLB miss ports.
// Ports: clk, reset (async, active-high), bus (page_walker_if.slave).
module page_walker
  import mmu_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int LEVELS = 4
) (
  input logic          clk,
  input logic          reset,
  page_walker_if.slave bus
);

  localparam int VA_BITS = PAGE_BITS + VPN_BITS * LEVELS;
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  localparam logic [1:0] IDLE  = PTW_IDLE;
  localparam logic [1:0] FETCH = PTW_FETCH;
  localparam logic [1:0] DONE  = PTW_DONE;
  localparam logic [1:0] DRAIN = PTW_DRAIN;

  logic [1:0]        state;
  logic [PW-1:0]     port;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic [51:0]       vpage;
  logic [51:0]       pt;
  logic [1:0]        level;
  logic [63:0]       res_addr;
  tlb_perm_bits      res_perms;
  logic              res_fault;
  logic [NPORTS-1:0] grant;
  logic [63:0]       va_g;
  logic [63:0]       pte;
  logic [43:0]       ppn;
  logic [43:0]       ppn_mix;
  logic [8:0]        vpn_cur;
  logic              canon;
  logic              misal;
  logic              bad;
  logic              is_ptr;
  logic              lvl0;
  logic              walk_fault;
  logic              descend;
  logic              hit;
  logic              use_dc;
  logic              done_ok;
  logic              unused_bits;

  rr_arbiter #(.N(NPORTS), .PW(PW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NPORTS; i++)
      if (grant[i]) gidx = PW'(i);
  end

  assign va_g  = bus.req_addr[gidx];
  assign canon = (&va_g[63:VA_BITS-1])
               | ~(|va_g[63:VA_BITS-1]);

  assign pte     = bus.dcache_resp_data;
  assign ppn     = pte[PPN_MSB:PPN_LSB];
  assign vpn_cur = vpage[VPN_BITS*level +: VPN_BITS];

  // Decode classes are mutually exclusive by construction.
  assign bad    = ~pte[PTE_V] | (pte[PTE_W] & ~pte[PTE_R]);
  assign is_ptr = ~bad & ~pte[PTE_R]
                & ~pte[PTE_W] & ~pte[PTE_X];
  assign lvl0   = (level == 2'd0);

  assign walk_fault = bad | (is_ptr & lvl0)
                    | (~bad & ~is_ptr & misal);
  assign descend    = is_ptr & ~lvl0;
  assign hit        = ~bad & ~is_ptr & ~misal;

  // Superpage: low PPN fields must be zero and are filled from the VA.
  always_comb begin
    misal   = 1'b0;
    ppn_mix = ppn;
    for (int i = 0; i < LEVELS - 1; i++) begin
      if (i < int'(level)) begin
        misal = misal | (|ppn[i*VPN_BITS +: VPN_BITS]);
        ppn_mix[i*VPN_BITS +: VPN_BITS] =
          vpage[i*VPN_BITS +: VPN_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      port      <= '0;
      rr_ptr    <= '0;
      vpage     <= '0;
      pt        <= '0;
      level     <= '0;
      res_addr  <= '0;
      res_perms <= '0;
      res_fault <= 1'b0;
    end else if (bus.flush) begin
      // A D-cache read in flight must complete before release.
      unique case (state)
        FETCH, DRAIN:
          state <= bus.dcache_resp_valid ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: if (|bus.req_valid) begin
          port   <= gidx;
          vpage  <= va_g[63:12];
          level  <= 2'(LEVELS - 1);
          pt     <= bus.root_pt_addr[63:12];
          rr_ptr <= (gidx == PW'(NPORTS - 1))
                  ? '0 : gidx + 1'b1;
          if (!canon) begin
            res_addr  <= '0;
            res_perms <= '0;
            res_fault <= 1'b1;
            state     <= DONE;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: if (bus.dcache_resp_valid) begin
          unique case (1'b1)
            walk_fault: begin
              res_addr  <= '0;
              res_perms <= '0;
              res_fault <= 1'b1;
              state     <= DONE;
            end
            descend: begin
              pt    <= {8'b0, ppn};
              level <= level - 1'b1;
            end
            hit: begin
              res_addr  <= {8'b0, ppn_mix, 12'b0};
              res_perms <= pte[7:0];
              res_fault <= 1'b0;
              state     <= DONE;
            end
          endcase
        end
        DONE: state <= IDLE;
        DRAIN: if (bus.dcache_resp_valid) state <= IDLE;
      endcase
    end
  end

  assign use_dc = (state == FETCH) | (state == DRAIN);
  assign bus.use_dcache = use_dc;
  assign bus.dcache_req_addr =
    use_dc ? {pt, vpn_cur, 3'b000} : '0;

  // Stale results (port dropped or re-targeted) are discarded.
  assign done_ok = (state == DONE) & ~bus.flush
                 & bus.req_valid[port]
                 & (bus.req_addr[port][63:12] == vpage);

  always_comb begin
    bus.resp_valid = '0;
    for (int i = 0; i < NPORTS; i++)
      bus.resp_valid[i] = done_ok & (port == PW'(i));
  end

  assign bus.resp_addr  = done_ok ? res_addr : '0;
  assign bus.resp_perms = done_ok ? res_perms : '0;
  assign bus.resp_fault = done_ok & res_fault;

  assign unused_bits = ^{pte[63:54], pte[9:8],
                         bus.root_pt_addr[11:0], va_g[11:0]};

endmodule
